// File: rtl/debounced_synchronizer.sv
// debounced_synchronizer
//   Multi-channel synchronizer for asynchronous, possibly bouncing inputs.
//   Each channel runs its own stageCount-deep sync chain. When
//   debounceCycles > 0 the channel also has a stability counter, and the
//   output only takes a new value after it has been seen for debounceCycles
//   consecutive edges. When debounceCycles == 0 the output is simply the
//   last sync stage.
//
//   Optional macro DEBOUNCED_SYNCHRONIZER_EDGE_EN builds registered one-cycle
//   edge pulses. Without it, risingEdge/fallingEdge are tied to 0.
//
// Parameters
//   width          number of independent channels
//   stageCount     sync flops per channel (>= 1)
//   debounceCycles stable edges required before dataOut follows (0 = off)
//   resetValue     per-channel value of sync stages and dataOut on reset
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-high reset
//   dataIn      [width] asynchronous inputs
//   dataOut     [width] synchronized, debounced levels (registered)
//   risingEdge  [width] one-cycle pulse when dataOut goes 0->1
//   fallingEdge [width] one-cycle pulse when dataOut goes 1->0

module debounced_synchronizer_lane #(
  parameter int   STAGES  = 2,
  parameter int   D       = 0,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;

  generate
    if (STAGES == 1) begin : g_s1
      always_comb sync_d = din;
    end else begin : g_sn
      always_comb sync_d = {sync_q[STAGES-2:0], din};
    end
  endgenerate

  always_ff @(posedge clock or posedge reset)
    if (reset) sync_q <= {STAGES{RST_VAL}};
    else       sync_q <= sync_d;

`ifdef DEBOUNCED_SYNCHRONIZER_EDGE_EN
  // High when dout takes a different value at the coming edge.
  logic chg;
`endif

  generate
    if (D == 0) begin : g_nofilt
      assign dout = sync_q[STAGES-1];
`ifdef DEBOUNCED_SYNCHRONIZER_EDGE_EN
      assign chg  = sync_d[STAGES-1] ^ sync_q[STAGES-1];
`endif
    end else begin : g_filt
      localparam int CW = $clog2(D + 1);
      logic [CW-1:0] cnt_q, cnt_d;
      logic          dout_q, dout_d;
      logic          synced;

      assign synced = sync_q[STAGES-1];

      // Counter only runs while synced disagrees with dout; any agreement
      // clears it, so a reverting glitch restarts the count from zero.
      always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (synced == dout_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(D - 1)) begin
          dout_d = synced;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clock or posedge reset)
        if (reset) begin
          cnt_q  <= '0;
          dout_q <= RST_VAL;
        end else begin
          cnt_q  <= cnt_d;
          dout_q <= dout_d;
        end

      assign dout = dout_q;
`ifdef DEBOUNCED_SYNCHRONIZER_EDGE_EN
      assign chg  = (synced != dout_q) && (cnt_q == CW'(D - 1));
`endif
    end
  endgenerate

`ifdef DEBOUNCED_SYNCHRONIZER_EDGE_EN
  logic rise_q, rise_d, fall_q, fall_d;

  // Direction comes from the current level: a change from 0 is a rise.
  always_comb begin
    rise_d = chg & ~dout;
    fall_d = chg &  dout;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

module debounced_synchronizer #(
  parameter int               width          = 1,
  parameter int               stageCount     = 2,
  parameter int               debounceCycles = 0,
  parameter logic [width-1:0] resetValue     = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] dataIn,
  output logic [width-1:0] dataOut,
  output logic [width-1:0] risingEdge,
  output logic [width-1:0] fallingEdge
);

  for (genvar i = 0; i < width; i++) begin : g_lane
    debounced_synchronizer_lane #(
      .STAGES  (stageCount),
      .D       (debounceCycles),
      .RST_VAL (resetValue[i])
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .din   (dataIn[i]),
      .dout  (dataOut[i]),
      .rise  (risingEdge[i]),
      .fall  (fallingEdge[i])
    );
  end

endmodule

// File: tb/tb_debounced_synchronizer.sv
// Directed bench for debounced_synchronizer. Three instances:
//   dut0: width 1, 2 stages, no filtering
//   dut1: width 4, 2 stages, debounce 3, reset value 0
//   dut2: width 4, 2 stages, debounce 3, reset value 4'b1010
module tb_debounced_synchronizer;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic       rst2  = 1'b0;
  logic       d0    = 1'b0;
  logic [3:0] d1    = 4'b0000;
  logic [3:0] d2    = 4'b1010;

  logic       o0, r0, f0;
  logic [3:0] o1, r1, f1;
  logic [3:0] o2, r2, f2;

  int n_chk = 0;
  int n_err = 0;

  always #10 clock = ~clock;

  debounced_synchronizer #(.width(1), .stageCount(2), .debounceCycles(0),
                           .resetValue(1'b0)) dut0 (
    .clock(clock), .reset(rst), .dataIn(d0),
    .dataOut(o0), .risingEdge(r0), .fallingEdge(f0));

  debounced_synchronizer #(.width(4), .stageCount(2), .debounceCycles(3),
                           .resetValue(4'b0000)) dut1 (
    .clock(clock), .reset(rst), .dataIn(d1),
    .dataOut(o1), .risingEdge(r1), .fallingEdge(f1));

  debounced_synchronizer #(.width(4), .stageCount(2), .debounceCycles(3),
                           .resetValue(4'b1010)) dut2 (
    .clock(clock), .reset(rst2), .dataIn(d2),
    .dataOut(o2), .risingEdge(r2), .fallingEdge(f2));

  // Expected edge pulse: the pulse itself when edge logic is built, else 0.
  function automatic logic [3:0] e(input logic [3:0] v);
`ifdef DEBOUNCED_SYNCHRONIZER_EDGE_EN
    return v;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic hist [0:7];

  initial begin
    #1 rst = 1'b1; rst2 = 1'b1;
    #5;
    chk("rst_o0", {7'd0, o0}, 8'h00);
    chk("rst_e0", {6'd0, r0, f0}, 8'h00);
    chk("rst_o1", {4'd0, o1}, 8'h00);
    chk("rst_e1", {r1, f1}, 8'h00);
    chk("rst_o2", {4'd0, o2}, 8'h0a);
    tick(1);
    rst = 1'b0; rst2 = 1'b0;

    // dut2: reset released with input equal to reset value -> quiet
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("rv_quiet_o2", {4'd0, o2}, 8'h0a);
      chk("rv_quiet_e2", {r2, f2}, 8'h00);
    end

    tick(40);
    chk("base_o0", {7'd0, o0}, 8'h00);
    chk("base_o1", {4'd0, o1}, 8'h00);

    // Scenario 1: D=0, 2-edge latency
    d0 = 1'b1;
    #1 chk("s1_1ns", {7'd0, o0}, 8'h00);
    tick(1); chk("s1_e1", {7'd0, o0}, 8'h00);
    tick(1); chk("s1_e2", {7'd0, o0}, 8'h01);
    chk("s1_rise", {7'd0, r0}, {4'd0, e(4'b0001)});
    chk("s1_fall", {7'd0, f0}, 8'h00);
    tick(1); chk("s1_rise_clr", {7'd0, r0}, 8'h00);
    d0 = 1'b0;
    tick(1); chk("s1b_e1", {7'd0, o0}, 8'h01);
    tick(1); chk("s1b_e2", {7'd0, o0}, 8'h00);
    chk("s1b_fall", {7'd0, f0}, {4'd0, e(4'b0001)});
    chk("s1b_rise", {7'd0, r0}, 8'h00);
    tick(1); chk("s1b_fall_clr", {7'd0, f0}, 8'h00);

    // Scenario 2: D=3 pass at edge 5, not edge 4
    d1 = 4'b0101;
    tick(4); chk("s2_e4", {4'd0, o1}, 8'h00);
    tick(1); chk("s2_e5", {4'd0, o1}, 8'h05);
    chk("s2_rise", {4'd0, r1}, {4'd0, e(4'b0101)});
    chk("s2_fall", {4'd0, f1}, 8'h00);
    tick(1); chk("s2_hold", {4'd0, o1}, 8'h05);
    chk("s2_rise_clr", {4'd0, r1}, 8'h00);
    d1 = 4'b0000;
    tick(4); chk("s2b_e4", {4'd0, o1}, 8'h05);
    tick(1); chk("s2b_e5", {4'd0, o1}, 8'h00);
    chk("s2b_fall", {4'd0, f1}, {4'd0, e(4'b0101)});
    tick(1); chk("s2b_fall_clr", {4'd0, f1}, 8'h00);

    // Toggling every cycle: D=0 follows with 2-edge delay, D=3 never passes
    for (int i = 0; i < 8; i++) begin
      hist[i] = (i % 2 == 0);
      d0 = hist[i];
      d1 = {3'b000, hist[i]};
      tick(1);
      if (i >= 1) begin
        chk("tog_o0", {7'd0, o0}, {7'd0, hist[i-1]});
        chk("tog_r0", {7'd0, r0}, {4'd0, e({3'b000, hist[i-1]})});
        chk("tog_f0", {7'd0, f0}, {4'd0, e({3'b000, ~hist[i-1]})});
      end
      chk("tog_o1", {4'd0, o1}, 8'h00);
    end
    d0 = 1'b0; d1 = 4'b0000;
    tick(6);
    chk("tog_end_o1", {4'd0, o1}, 8'h00);
    chk("tog_end_e1", {r1, f1}, 8'h00);

    // Scenario 3a: 2-edge glitch rejected
    d1 = 4'b0100;
    tick(2);
    d1 = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("gl2_o1", {4'd0, o1}, 8'h00);
      chk("gl2_e1", {r1, f1}, 8'h00);
    end

    // Scenario 3b: 3-edge pulse passes, high for 3 cycles
    d1 = 4'b0100;
    tick(3);
    d1 = 4'b0000;
    tick(1); chk("gl3_e4", {4'd0, o1}, 8'h00);
    tick(1); chk("gl3_e5", {4'd0, o1}, 8'h04);
    chk("gl3_rise", {r1, f1}, {e(4'b0100), 4'h0});
    tick(1); chk("gl3_e6", {4'd0, o1}, 8'h04);
    chk("gl3_e6_e", {r1, f1}, 8'h00);
    tick(1); chk("gl3_e7", {4'd0, o1}, 8'h04);
    tick(1); chk("gl3_e8", {4'd0, o1}, 8'h00);
    chk("gl3_fall", {r1, f1}, {4'h0, e(4'b0100)});
    tick(1); chk("gl3_e9_e", {r1, f1}, 8'h00);

    // Scenario 5: independent channels two cycles apart
    d1 = 4'b0001;
    tick(2);
    d1 = 4'b1001;
    tick(2); chk("ind_e4", {4'd0, o1}, 8'h00);
    tick(1); chk("ind_e5", {4'd0, o1}, 8'h01);
    chk("ind_e5_r", {4'd0, r1}, {4'd0, e(4'b0001)});
    tick(1); chk("ind_e6", {4'd0, o1}, 8'h01);
    chk("ind_e6_r", {4'd0, r1}, 8'h00);
    tick(1); chk("ind_e7", {4'd0, o1}, 8'h09);
    chk("ind_e7_r", {4'd0, r1}, {4'd0, e(4'b1000)});
    tick(1); chk("ind_e8_r", {4'd0, r1}, 8'h00);

    // Scenario 4: reset mid-count between edges on dut2
    d2 = 4'b0101;
    tick(3);
    chk("rv_pre", {4'd0, o2}, 8'h0a);
    #5 rst2 = 1'b1;
    #1;
    chk("rv_async_o2", {4'd0, o2}, 8'h0a);
    chk("rv_async_e2", {r2, f2}, 8'h00);
    d2 = 4'b1010;
    tick(1);
    chk("rv_held_o2", {4'd0, o2}, 8'h0a);
    rst2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("rv_post_o2", {4'd0, o2}, 8'h0a);
      chk("rv_post_e2", {r2, f2}, 8'h00);
    end

    // Reset of dut1 while channels high returns to resetValue 0 immediately
    #3 rst = 1'b1;
    #1 chk("rst_mid_o1", {4'd0, o1}, 8'h00);
    chk("rst_mid_e1", {r1, f1}, 8'h00);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/debounced_synchronizer.md
# debounced_synchronizer

- Multi-channel input synchronizer with a per-channel debounce filter and optional one-cycle edge pulses.
- Brings asynchronous, possibly bouncing signals into the `clock` domain: buttons, switches, external status lines, UART RX idle detect.
- Successor to the fixed single-bit synchronizer; with `debounceCycles = 0` and `width = 1`, `dataOut` behaves exactly like that block.

## Interface
Parameters:
- `width`, 1: number of independent channels.
- `stageCount`, 2: flip-flop stages in the synchronizer chain; must be ≥ 1.
- `debounceCycles`, 0: cycles a synchronized value must stay stable before `dataOut` takes it; 0 means no filtering.
- `resetValue`, all zeros (`width` bits): per-channel value loaded on reset.

Ports:
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `dataIn` input `width`: asynchronous inputs.
- `dataOut` output `width`: synchronized, debounced level per channel (registered).
- `risingEdge` output `width`: one-cycle pulse per channel when `dataOut` goes 0→1.
- `fallingEdge` output `width`: one-cycle pulse per channel when `dataOut` goes 1→0.

## Operation
- **Sync chain.** Each channel has a `stageCount`-deep shift register clocked by `clock`. `synced[i]` is its last stage.
- **Debounce counter.** Each channel has a counter `cnt[i]` of width clog2(`debounceCycles`+1). Per rising edge, for `debounceCycles` = D ≥ 1:
  - `synced[i] == dataOut[i]`: set `cnt[i]` to 0.
  - Otherwise, if `cnt[i] == D-1`: set `dataOut[i]` to `synced[i]` and `cnt[i]` to 0.
  - Otherwise: increment `cnt[i]`.
- **Glitch rejection.** A change at `synced[i]` that reverts before D consecutive differing edges is discarded. The counter restarts from 0 on the next change. Saturation and wrap-around are impossible.
- **No filtering.** With D = 0, no counter is built and `dataOut[i]` is the last sync stage.
- **Independence.** Channels do not interact. Simultaneous changes on several channels are each filtered independently.
- **Edge pulses.** Edge flags are registered in the same edge that updates `dataOut[i]`.
  - `risingEdge[i]` is high for exactly the first cycle in which `dataOut[i]` holds the new value 1.
  - `fallingEdge[i]` is high for exactly the first cycle in which `dataOut[i]` holds the new value 0.
  - `risingEdge[i]` and `fallingEdge[i]` are never high together.
- **Reset.**
  - Outputs: all sync stages and `dataOut` load `resetValue`; counters load 0; `risingEdge` and `fallingEdge` load 0.
  - Mid-operation: a reset discards pending counts and in-flight sync values immediately, independent of `clock`.
  - After release: no edge pulse is generated merely because `dataIn` differs from `resetValue`. A differing input appears at `dataOut` after the full latency below, with a normal edge pulse.

## Timing
- **Latency.** Let `dataIn[i]` change before rising edge 1 and stay stable.
  - `synced[i]` updates at edge `stageCount`.
  - `dataOut[i]` updates at edge `stageCount + D`.
  - The edge pulse is visible in the same cycle and clears at the following edge.
- **Reference numbers.** With a 20 ns clock, `stageCount = 2`, D = 0: new value visible 40 ns after the input change, measured from the first edge. Not visible after 1 edge.
- **Glitch threshold.** An input pulse must cover ≥ D consecutive sampled edges at `synced` to pass. A pulse of D-1 edges produces no output change and no edge pulse.
- **Toggling input.** An input toggled every cycle with D = 0 appears toggled at `dataOut` with a `stageCount`-cycle delay, with an edge pulse every cycle. With D ≥ 2 it never passes.
- **No combinational paths.** No path from `dataIn` or `reset` to outputs other than the asynchronous reset clear.

## Configuration
- Macro: `DEBOUNCED_SYNCHRONIZER_EDGE_EN`.
- Defined: the edge-flag registers are built and `risingEdge`/`fallingEdge` behave as above.
- Undefined: no edge logic is compiled; `risingEdge` and `fallingEdge` are constant 0. `dataOut` timing is unchanged.

## Test plan
All scenarios use a 20 ns clock.

1. **Baseline.** `width=1`, `stageCount=2`, D=0, reset then `dataIn=0` for 1000 ns → `dataOut=0`. Set `dataIn=1` → `dataOut=0` at +1 ns and after 1 edge, `dataOut=1` after 2 edges. Same pattern back to 0.
2. **Debounce pass.** `width=4`, D=3, `dataIn` 4'b0000→4'b0101 stable → `dataOut=4'b0101` exactly at edge 5 (not edge 4). `risingEdge=4'b0101` for one cycle, `fallingEdge=0`.
3. **Glitch reject.** D=3, `dataIn[2]` high for exactly 2 edges, then low → `dataOut` stays 4'b0000 for 20 cycles, no edge pulses. Repeat with 3 edges → `dataOut[2]` pulses high for 3 cycles, with one `risingEdge[2]` and one `fallingEdge[2]`.
4. **Reset value.** `resetValue=4'b1010`, `reset` asserted mid-count, between edges → `dataOut=4'b1010` and edges 0 immediately. After release with `dataIn=4'b1010`, no pulses for 10 cycles.
5. **Independent channels.** D=3: `dataIn[0]` 0→1 and `dataIn[3]` 0→1 two cycles apart → each `dataOut` bit updates 5 edges after its own change. Pulses do not overlap across bits.
6. **Macro undefined.** Rerun scenario 2 without `DEBOUNCED_SYNCHRONIZER_EDGE_EN` → identical `dataOut`; `risingEdge` and `fallingEdge` are 0 throughout.
